// File: rtl/y_arb_pkg.sv
// Shared types and constants for the Y SRAM arbiter: FSM state encoding,
// idle bus address and hold-counter sizing.
package y_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOVER
  } state_t;

  localparam int Y_ADDR_W = 11;
  localparam logic [Y_ADDR_W-1:0] Y_IDLE_ADDR = '1;

  // Counter must hold 0..max_hold; keep at least one bit when the timeout is disabled.
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/y_rr_picker.sv
// Combinational round-robin picker: first active request at or after the
// pointer, wrapping modulo NUM_REQ.
module y_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic             w_found;
  logic [PTR_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = |i_req;
    w_found  = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_pos]) begin
        w_found         = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
      end
    end
  end

endmodule

// File: rtl/y_sram_arbiter.sv
// Round-robin request/grant arbiter for the single Y SRAM port, with hold
// lock, one-cycle handover gap and optional starvation timeout.
module y_sram_arbiter
  import y_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = Y_ADDR_W,
  parameter int DATA_W   = 256,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_req,
  input  logic [NUM_REQ*ADDR_W-1:0] in_readAddr1,
  input  logic [NUM_REQ*ADDR_W-1:0] in_readAddr2,
  input  logic [NUM_REQ-1:0]        in_we,
  input  logic [NUM_REQ*ADDR_W-1:0] in_writeAddr,
  input  logic [NUM_REQ*DATA_W-1:0] in_writeData,
  output logic [NUM_REQ-1:0]        op_grant,
  output logic                      op_busy,
  output logic                      op_timeout,
  output logic [ADDR_W-1:0]         op_yReadAddress1,
  output logic [ADDR_W-1:0]         op_yReadAddress2,
  output logic                      op_yWriteEnable,
  output logic [ADDR_W-1:0]         op_yWriteAddress,
  output logic [DATA_W-1:0]         op_writeData
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_LIM   = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] IDLE_ADDR = '1;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy;
  logic               r_timeout, w_timeout_nxt;

  logic [NUM_REQ-1:0] w_win_oh;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_any;
  logic               w_others;

  y_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (in_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_others = |(in_req & ~r_grant);

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      GRANT: begin
        w_cnt_nxt = (r_cnt < CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
        if (!in_req[r_owner]) begin
          w_state_nxt = HANDOVER;
          w_grant_nxt = '0;
        end else if ((MAX_HOLD != 0) && (r_cnt >= CNT_LIM) && w_others) begin
          // Limit reached with someone waiting: pre-empt; the loser sits last in RR order.
          w_state_nxt   = HANDOVER;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        if (w_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_win_oh;
          w_owner_nxt = w_win_idx;
          w_ptr_nxt   = (w_win_idx == PTR_LAST) ? '0 : w_win_idx + 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt == GRANT);
      r_timeout <= w_timeout_nxt;
    end
  end

  assign op_grant   = r_grant;
  assign op_busy    = r_busy;
  assign op_timeout = r_timeout;

  // SRAM pins: combinational mux of the owner's slices, idle values otherwise.
  always_comb begin
    op_yReadAddress1 = IDLE_ADDR;
    op_yReadAddress2 = IDLE_ADDR;
    op_yWriteAddress = IDLE_ADDR;
    op_yWriteEnable  = 1'b0;
    op_writeData     = '0;
    if (r_busy) begin
      op_yReadAddress1 = in_readAddr1[r_owner*ADDR_W +: ADDR_W];
      op_yReadAddress2 = in_readAddr2[r_owner*ADDR_W +: ADDR_W];
      op_yWriteAddress = in_writeAddr[r_owner*ADDR_W +: ADDR_W];
      op_yWriteEnable  = in_we[r_owner];
      op_writeData     = in_writeData[r_owner*DATA_W +: DATA_W];
    end
  end

endmodule
